// File: rtl/bus_cycle_generator.sv
// bus_cycle_generator
//   Bus master that runs 8088-style bus cycles (T1-T2-T3-[Tw]-T4) on behalf of
//   a non-CPU master (DMA, refresh, debug bridge). A request is accepted in IDLE
//   on a CPU-clock falling edge. The CPU-side status and strobes are then driven
//   with the same timing the CPU itself would produce. The downstream bus
//   controller decodes these into MEMR_N/MEMW_N/IOR_N/IOW_N.
//
//   Ports
//     clock, reset             system clock, synchronous active-high reset
//     cpu_clock_posedge/negedge one-clock enables for CPU clock rise/fall
//     req, req_io, req_write   cycle request and its type
//     req_address, req_data    cycle address and write data
//     ready, bus_data_in       bus READY and read data from the bus
//     busy, ack, timeout       cycle in progress, completion pulse, wait expiry
//     rd_data                  captured read data (0xFF after a timeout)
//     ALE, RD_N, WR_N          address latch enable and active-low strobes
//     IO_OR_M, DT_OR_R         I/O-vs-memory and transmit-vs-receive status
//     address, data_out        cycle address and write data to the bus
//     data_out_enable          drive data_out onto the bus
module bus_cycle_generator #(
  parameter logic [7:0] MAX_WAIT = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_clock_posedge,
  input  logic        cpu_clock_negedge,
  input  logic        req,
  input  logic        req_io,
  input  logic        req_write,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_data,
  input  logic        ready,
  input  logic [7:0]  bus_data_in,
  output logic        busy,
  output logic        ack,
  output logic        timeout,
  output logic [7:0]  rd_data,
  output logic        ALE,
  output logic        RD_N,
  output logic        WR_N,
  output logic        IO_OR_M,
  output logic        DT_OR_R,
  output logic [19:0] address,
  output logic [7:0]  data_out,
  output logic        data_out_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  wait_cnt, wait_cnt_nx;
  logic        ready_q, ready_q_nx;
  logic        write_q, write_q_nx;
  logic [7:0]  wdata_q, wdata_q_nx;
  logic        expired, expired_nx;

  logic        busy_nx, ack_nx, timeout_nx;
  logic [7:0]  rd_data_nx;
  logic        ale_nx, rd_n_nx, wr_n_nx, io_or_m_nx, dt_or_r_nx;
  logic [19:0] address_nx;
  logic [7:0]  data_out_nx;
  logic        data_out_enable_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_cnt        <= 8'd0;
      ready_q         <= 1'b0;
      write_q         <= 1'b0;
      wdata_q         <= 8'd0;
      expired         <= 1'b0;
      busy            <= 1'b0;
      ack             <= 1'b0;
      timeout         <= 1'b0;
      rd_data         <= 8'd0;
      ALE             <= 1'b0;
      RD_N            <= 1'b1;
      WR_N            <= 1'b1;
      IO_OR_M         <= 1'b0;
      DT_OR_R         <= 1'b1;
      address         <= 20'd0;
      data_out        <= 8'd0;
      data_out_enable <= 1'b0;
    end else begin
      state           <= state_nx;
      wait_cnt        <= wait_cnt_nx;
      ready_q         <= ready_q_nx;
      write_q         <= write_q_nx;
      wdata_q         <= wdata_q_nx;
      expired         <= expired_nx;
      busy            <= busy_nx;
      ack             <= ack_nx;
      timeout         <= timeout_nx;
      rd_data         <= rd_data_nx;
      ALE             <= ale_nx;
      RD_N            <= rd_n_nx;
      WR_N            <= wr_n_nx;
      IO_OR_M         <= io_or_m_nx;
      DT_OR_R         <= dt_or_r_nx;
      address         <= address_nx;
      data_out        <= data_out_nx;
      data_out_enable <= data_out_enable_nx;
    end
  end

  always_comb begin
    state_nx           = state;
    wait_cnt_nx        = wait_cnt;
    ready_q_nx         = ready_q;
    write_q_nx         = write_q;
    wdata_q_nx         = wdata_q;
    expired_nx         = expired;
    busy_nx            = busy;
    ack_nx             = 1'b0;
    timeout_nx         = 1'b0;
    rd_data_nx         = rd_data;
    ale_nx             = ALE;
    rd_n_nx            = RD_N;
    wr_n_nx            = WR_N;
    io_or_m_nx         = IO_OR_M;
    dt_or_r_nx         = DT_OR_R;
    address_nx         = address;
    data_out_nx        = data_out;
    data_out_enable_nx = data_out_enable;

    unique case (state)
      S_IDLE: begin
        if (cpu_clock_negedge && req) begin
          state_nx    = S_T1;
          write_q_nx  = req_write;
          wdata_q_nx  = req_data;
          wait_cnt_nx = 8'd0;
          expired_nx  = 1'b0;
          ale_nx      = 1'b1;
          io_or_m_nx  = req_io;
          dt_or_r_nx  = req_write;
          address_nx  = req_address;
          busy_nx     = 1'b1;
        end
      end

      S_T1: begin
        if (cpu_clock_posedge) begin
          ale_nx = 1'b0;
        end
        if (cpu_clock_negedge) begin
          // ALE is also dropped here so it can never overlap a strobe,
          // even if no CPU rising edge was flagged during T1.
          state_nx = S_T2;
          ale_nx   = 1'b0;
          if (write_q) begin
            wr_n_nx            = 1'b0;
            data_out_nx        = wdata_q;
            data_out_enable_nx = 1'b1;
          end else begin
            rd_n_nx = 1'b0;
          end
        end
      end

      S_T2: begin
        if (cpu_clock_negedge) begin
          state_nx = S_T3;
        end
      end

      S_T3, S_TW: begin
        if (cpu_clock_posedge) begin
          ready_q_nx = ready;
        end
        if (cpu_clock_negedge) begin
          if (ready_q) begin
            state_nx = S_T4;
            rd_n_nx  = 1'b1;
            wr_n_nx  = 1'b1;
            if (!write_q) begin
              rd_data_nx = bus_data_in;
            end
          end else if (state == S_TW && wait_cnt >= MAX_WAIT) begin
            // Wait budget exhausted: finish the cycle as if READY had
            // arrived, but flag it and return a recognisable data value.
            state_nx   = S_T4;
            rd_n_nx    = 1'b1;
            wr_n_nx    = 1'b1;
            expired_nx = 1'b1;
            rd_data_nx = 8'hFF;
          end else begin
            state_nx = S_TW;
            if (wait_cnt != 8'hFF) begin
              wait_cnt_nx = wait_cnt + 8'd1;
            end
          end
        end
      end

      S_T4: begin
        if (cpu_clock_negedge) begin
          state_nx           = S_IDLE;
          data_out_enable_nx = 1'b0;
          dt_or_r_nx         = 1'b1;
          busy_nx            = 1'b0;
          ack_nx             = 1'b1;
          timeout_nx         = expired;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
